vmat_store_unit: RTL
====================

# vmat_store_unit

Matrix writeback serializer for the vector ALU datapath. It captures a full VEC_COUNT x VEC_COUNT result matrix, presented as an array of packed rows in the same layout the VALU produces. It then drains the matrix to the data-memory write port one element per handshake, in row-major order, with computed byte addresses. It is the store-side counterpart to the matrix operand path: the VALU produces whole matrices combinationally, and this block turns them back into a sequential memory write stream.

## Interface
Parameters:
- ELEM_WIDTH, 32, bits per matrix element; must be a multiple of 8.
- VEC_COUNT, 4, rows and columns per matrix (square).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  request to capture mat_i and begin a store; sampled only in IDLE.
- mat_i  in  [ELEM_WIDTH*VEC_COUNT-1:0] x [VEC_COUNT]  result matrix; row i is mat_i[i]; element (i,j) is mat_i[i][ELEM_WIDTH*(j+1)-1 -: ELEM_WIDTH].
- base_addr_i  in  ADDR_WIDTH  byte address of element (0,0); sampled with start_i.
- row_stride_i  in  ADDR_WIDTH  byte distance between row starts; sampled with start_i.
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse after the last element is accepted.
- req_valid_o  out  1  write request valid.
- req_ready_i  in  1  memory accepts the request this cycle.
- req_addr_o  out  ADDR_WIDTH  byte address of the current element.
- req_wdata_o  out  ELEM_WIDTH  current element data.

## Operation
- Clock and reset: one clock (clk); reset_n is asynchronous and active-low.
- States: IDLE, SEND, DONE.
- IDLE:
  - start_i=1 registers mat_i (full copy), base_addr_i and row_stride_i, and clears row/col counters.
  - Go to SEND.
  - mat_i changes after capture do not affect the stream.
- SEND:
  - Drive element (row, col) with addr = base + row*row_stride + col*(ELEM_WIDTH/8), modulo 2^ADDR_WIDTH (wrap, no error).
  - On handshake (req_valid_o & req_ready_i): col increments. At col=VEC_COUNT-1, col goes to 0 and row increments.
  - On the handshake of element (VEC_COUNT-1, VEC_COUNT-1), go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i while busy (SEND or DONE) is ignored, not queued.
- Element order: row-major, (0,0),(0,1),…,(0,N-1),(1,0),…; exactly VEC_COUNT² requests per start.
- Reset at any point, including mid-stream: the transfer is aborted with no completion pulse. All state returns to IDLE and outputs take their reset values immediately.

## Timing
- Reset values: busy_o=0, done_o=0, req_valid_o=0, req_addr_o=0, req_wdata_o=0; internal counters and captured matrix =0.
- All outputs are registered; no combinational path from req_ready_i or start_i to any output.
- Cycle numbering:
  - start_i accepted at edge of cycle 0.
  - Cycle 1: req_valid_o=1 with element (0,0), busy_o=1.
- req_valid_o stays high continuously from cycle 1 until the final handshake. It never drops between elements.
- With req_ready_i held at 1:
  - One element per cycle; elements occupy cycles 1..VEC_COUNT².
  - done_o is high in cycle VEC_COUNT²+1; busy_o is high in cycles 1..VEC_COUNT²+1.
  - IDLE in cycle VEC_COUNT²+2, where a new start_i may be accepted.
- Backpressure: while req_valid_o=1 and req_ready_i=0, req_addr_o and req_wdata_o hold stable.
- After the final handshake, req_valid_o=0 in the following (DONE) cycle.
- req_addr_o and req_wdata_o are don't-care when req_valid_o=0, but are held at their last values (no toggling).

## Test plan
- Reset then idle, with req_ready_i=1 and start_i=0 for 10 cycles -> all outputs remain 0.
- Store without backpressure. Setup: mat_i[i][j] = 16*i+j, base=0x1000, stride=0x10, ready=1. Expected: 16 requests in cycles 1..16; addr 0x1000,0x1004,…,0x100C,0x1010,…,0x103C; data 0..3,16..19,…,48..51; done_o pulses in cycle 17 only; busy_o falls in cycle 18.
- Backpressure. Same setup, with ready low for 3 cycles before each odd-numbered element. Expected: addr/data stable during stalls, no skipped or duplicated elements, done_o after the 16th accept.
- Restart and capture isolation:
  - start_i held high throughout and mat_i changed mid-stream -> the stream carries the originally captured values.
  - The second start is accepted only in the first IDLE cycle after done_o.
- Address wrap: base=0xFFFF_FFF8, stride=0x10 -> element (0,2) addr=0x0000_0000; element (1,0) addr=0x0000_0008.
- Reset mid-stream: reset_n asserted after the 5th accept -> req_valid_o and busy_o drop immediately, no done_o. A fresh start then streams from element (0,0).

Source files
------------

// File: rtl/vmat_store_unit.sv
// Captures a VEC_COUNT x VEC_COUNT matrix and writes it out one element per handshake, row-major with byte addresses.
// First request is valid one cycle after start; req_ready_i low holds the current request stable; start_i is ignored while busy.
module vmat_store_unit #(
  parameter int ELEM_WIDTH = 32,
  parameter int VEC_COUNT  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start_i,
  input  logic [ELEM_WIDTH*VEC_COUNT-1:0]  mat_i [VEC_COUNT],
  input  logic [ADDR_WIDTH-1:0]            base_addr_i,
  input  logic [ADDR_WIDTH-1:0]            row_stride_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             req_valid_o,
  input  logic                             req_ready_i,
  output logic [ADDR_WIDTH-1:0]            req_addr_o,
  output logic [ELEM_WIDTH-1:0]            req_wdata_o
);

  localparam int                    CW         = (VEC_COUNT > 1) ? $clog2(VEC_COUNT) : 1;
  localparam logic [CW-1:0]         LAST_IDX   = CW'(VEC_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ELEM_BYTES = ADDR_WIDTH'(ELEM_WIDTH / 8);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                      state_q, state_d;
  logic [ELEM_WIDTH*VEC_COUNT-1:0] mat_q [VEC_COUNT];
  logic [ELEM_WIDTH*VEC_COUNT-1:0] mat_d [VEC_COUNT];
  logic [ADDR_WIDTH-1:0]           stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]           row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [ELEM_WIDTH-1:0]           wdata_q, wdata_d;
  logic [CW-1:0]                   row_q, row_d;
  logic [CW-1:0]                   col_q, col_d;
  logic [CW-1:0]                   row_nxt, col_nxt;
  logic                            hs, last_col, last_elem;

  // Addresses advance incrementally: row_base tracks the start of the current row, so no multiplier is needed.
  always_comb begin
    state_d    = state_q;
    mat_d      = mat_q;
    stride_d   = stride_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    row_d      = row_q;
    col_d      = col_q;
    row_nxt    = row_q + CW'(1);
    col_nxt    = col_q + CW'(1);
    hs         = (state_q == SEND) && req_ready_i;
    last_col   = (col_q == LAST_IDX);
    last_elem  = last_col && (row_q == LAST_IDX);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mat_d      = mat_i;
          stride_d   = row_stride_i;
          row_base_d = base_addr_i;
          addr_d     = base_addr_i;
          wdata_d    = mat_i[0][ELEM_WIDTH-1:0];
          row_d      = '0;
          col_d      = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (last_elem) begin
            row_d   = '0;
            col_d   = '0;
            state_d = DONE;
          end else if (last_col) begin
            row_d      = row_nxt;
            col_d      = '0;
            row_base_d = row_base_q + stride_q;
            addr_d     = row_base_q + stride_q;
            wdata_d    = mat_q[row_nxt][ELEM_WIDTH-1:0];
          end else begin
            col_d   = col_nxt;
            addr_d  = addr_q + ELEM_BYTES;
            wdata_d = mat_q[row_q][col_nxt*ELEM_WIDTH +: ELEM_WIDTH];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mat_q      <= '{default: '0};
      stride_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      mat_q      <= mat_d;
      stride_q   <= stride_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign req_valid_o = (state_q == SEND);
  assign req_addr_o  = addr_q;
  assign req_wdata_o = wdata_q;

endmodule
